// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter: valid/ready word in, one bit per clock out
// with bit-valid and frame marker. Optional even-parity slot enabled by `define PARITY_EN.
module piso_serial_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             sout_d, sout_valid_d, frame_start_d;
  logic             last_slot, accept;
`ifdef PARITY_EN
  logic             par, par_d;
`endif

  // The word is kept with the bit currently on sout at the outgoing end.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic next_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-2] : w[1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

`ifdef PARITY_EN
  assign last_slot = (state == PARITY);
`else
  assign last_slot = (state == SHIFT) && (cnt == LAST);
`endif

  assign din_ready = reset && ((state == IDLE) || last_slot);
  assign accept    = din_valid && din_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_d       = state;
    shreg_d       = shreg;
    cnt_d         = cnt;
    sout_d        = 1'b0;
    sout_valid_d  = 1'b0;
    frame_start_d = 1'b0;
`ifdef PARITY_EN
    par_d         = par;
`endif
    if (accept) begin
      state_d       = SHIFT;
      shreg_d       = din;
      cnt_d         = '0;
      sout_d        = first_bit(din);
      sout_valid_d  = 1'b1;
      frame_start_d = 1'b1;
`ifdef PARITY_EN
      par_d         = ^din;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != LAST) begin
            shreg_d      = shift_word(shreg);
            cnt_d        = cnt + CNT_W'(1);
            sout_d       = next_bit(shreg);
            sout_valid_d = 1'b1;
          end else begin
`ifdef PARITY_EN
            state_d      = PARITY;
            sout_d       = par;
            sout_valid_d = 1'b1;
`else
            state_d      = IDLE;
            cnt_d        = '0;
`endif
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
`ifdef PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      shreg       <= shreg_d;
      cnt         <= cnt_d;
      sout        <= sout_d;
      sout_valid  <= sout_valid_d;
      frame_start <= frame_start_d;
`ifdef PARITY_EN
      par         <= par_d;
`endif
    end
  end

endmodule
